// File: rtl/uart_cmd_ctrl_if.sv
// uart_cmd_ctrl_if: byte input, configuration and status signals of the UART command controller
//   rx_valid/rx_data            : received byte from the UART receiver
//   speed/set_speed             : baud configuration to the receiver
//   reg_wr_en/reg_addr/reg_wdata: register-write bus
//   ctrl_out                    : control byte
//   frame_ok/err_*              : one-cycle status pulses
//   busy                        : parser not idle
interface uart_cmd_ctrl_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [12:0] speed;
    logic        set_speed;
    logic        reg_wr_en;
    logic [7:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  ctrl_out;
    logic        frame_ok;
    logic        err_chk;
    logic        err_cmd;
    logic        err_timeout;
    logic        busy;
    modport slave (
        input  rx_valid, rx_data,
        output speed, set_speed, reg_wr_en, reg_addr, reg_wdata, ctrl_out,
               frame_ok, err_chk, err_cmd, err_timeout, busy
    );
    modport master (
        output rx_valid, rx_data,
        input  speed, set_speed, reg_wr_en, reg_addr, reg_wdata, ctrl_out,
               frame_ok, err_chk, err_cmd, err_timeout, busy
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses SYNC/CMD/P0/P1/CHK frames from the UART receiver and executes them
//   clk   : system clock
//   reset : synchronous active-low reset
//   bus   : uart_cmd_ctrl_if.slave (byte input, speed config, register bus, ctrl byte, status)
module uart_cmd_ctrl #(
    parameter logic [7:0]      SYNC_BYTE      = 8'hA5,
    parameter logic [12:0]     MIN_SPEED      = 13'd16,
    parameter logic [12:0]     SPEED_DEFAULT  = 13'h1869,
    parameter int              TO_W           = 20,
    parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 20'd250000
) (
    input logic             clk,
    input logic             reset,
    uart_cmd_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, GET_CMD, GET_P0, GET_P1, GET_CHK, EXEC} state_t;
    state_t state, state_n;
    logic rx_valid_q, stb, in_frame, to_hit, bad_chk, bad_cmd, exec_ok;
    logic [7:0] cmd, p0, p1, chk;
    logic [12:0] new_speed;
    logic [TO_W-1:0] cnt;

    // only the rising edge of the level-style rx_valid counts as a byte
    assign stb      = bus.rx_valid & ~rx_valid_q;
    assign in_frame = state inside {GET_CMD, GET_P0, GET_P1, GET_CHK};
    // a strobe in the limit cycle wins over the timeout
    assign to_hit   = in_frame && cnt == TIMEOUT_CYCLES - 1'b1 && !stb;

    always_ff @(posedge clk)
        if (!reset) state <= IDLE;
        else        state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:                             if (stb && bus.rx_data == SYNC_BYTE) state_n = GET_CMD;
            GET_CMD, GET_P0, GET_P1, GET_CHK: state_n = stb ? state_t'(state + 3'd1) : to_hit ? IDLE : state;
            default:                          state_n = IDLE;
        endcase
    end

    always_comb begin
        new_speed = {p0[4:0], p1};
        bad_chk   = chk != (cmd ^ p0 ^ p1);
        bad_cmd   = !(cmd inside {8'h01, 8'h02, 8'h03}) || (cmd == 8'h01 && new_speed < MIN_SPEED);
        exec_ok   = state == EXEC && !bad_chk && !bad_cmd;
        bus.busy  = state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_valid_q <= 1'b0;
            cnt        <= '0;
            cmd        <= '0;
            p0         <= '0;
            p1         <= '0;
            chk        <= '0;
        end else begin
            rx_valid_q <= bus.rx_valid;
            // counting only while the next state is a byte-wait state clears it on entering IDLE
            cnt        <= (stb || !(state_n inside {GET_CMD, GET_P0, GET_P1, GET_CHK})) ? '0 : cnt + 1'b1;
            if (stb && state == GET_CMD) cmd <= bus.rx_data;
            if (stb && state == GET_P0)  p0  <= bus.rx_data;
            if (stb && state == GET_P1)  p1  <= bus.rx_data;
            if (stb && state == GET_CHK) chk <= bus.rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.speed       <= SPEED_DEFAULT;
            bus.reg_addr    <= '0;
            bus.reg_wdata   <= '0;
            bus.ctrl_out    <= '0;
            bus.set_speed   <= 1'b0;
            bus.reg_wr_en   <= 1'b0;
            bus.frame_ok    <= 1'b0;
            bus.err_chk     <= 1'b0;
            bus.err_cmd     <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            bus.set_speed   <= exec_ok && cmd == 8'h01;
            bus.reg_wr_en   <= exec_ok && cmd == 8'h02;
            bus.frame_ok    <= exec_ok;
            bus.err_chk     <= state == EXEC && bad_chk;
            bus.err_cmd     <= state == EXEC && !bad_chk && bad_cmd;
            bus.err_timeout <= to_hit;
            if (exec_ok && cmd == 8'h01) bus.speed <= new_speed;
            if (exec_ok && cmd == 8'h02) begin
                bus.reg_addr  <= p0;
                bus.reg_wdata <= p1;
            end
            if (exec_ok && cmd == 8'h03) bus.ctrl_out <= p1;
        end
    end
endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command/configuration controller that sits behind the UART receiver. It consumes received bytes (byte-valid plus data), parses fixed-length command frames and checks their checksum. It drives the receiver's baud configuration (speed/set_speed), a simple register-write bus and an 8-bit control output. Errors are reported as single-cycle pulses. A frame timeout recovers the parser from truncated frames.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker.
MIN_SPEED, 13'd16, smallest accepted cycles-per-bit value.
SPEED_DEFAULT, 13'h1869, speed value after reset.
TO_W, 20, width of the timeout counter.
TIMEOUT_CYCLES, 20'd250000, idle cycles allowed between bytes inside a frame.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
rx_valid  in  1  byte-valid from the UART receiver; level signal, only the rising edge counts
rx_data  in  8  received byte, valid when rx_valid is high
speed  out  13  cycles-per-bit value to the receiver
set_speed  out  1  one-cycle pulse, load speed into the receiver
reg_wr_en  out  1  one-cycle register-write strobe
reg_addr  out  8  register address; holds its value after the write
reg_wdata  out  8  register data; holds its value after the write
ctrl_out  out  8  control byte; holds its value until the next CTRL command
frame_ok  out  1  one-cycle pulse, frame executed
err_chk  out  1  one-cycle pulse, checksum mismatch
err_cmd  out  1  one-cycle pulse, unknown command or speed below MIN_SPEED
err_timeout  out  1  one-cycle pulse, frame abandoned on timeout
busy  out  1  high in any state other than IDLE

Behaviour:
- Byte strobe: stb = rx_valid & ~rx_valid_q, where rx_valid_q is a registered copy of rx_valid (reset value 0).
  - Holding rx_valid high produces exactly one strobe.
  - rx_data is sampled on the clk edge where stb = 1.
- Frame format: SYNC, CMD, P0, P1, CHK. Fixed length; CHK = CMD ^ P0 ^ P1.
- Commands:
  - 0x01 SET_SPEED: speed = {P0[4:0], P1}; P0[7:5] are ignored.
  - 0x02 WRITE_REG: reg_addr = P0, reg_wdata = P1.
  - 0x03 CTRL: ctrl_out = P1; P0 is ignored.
- States: IDLE, GET_CMD, GET_P0, GET_P1, GET_CHK, EXEC.
  - IDLE: a strobe with rx_data == SYNC_BYTE moves to GET_CMD. Any other byte is dropped with no error.
  - GET_CMD, GET_P0, GET_P1: each strobe latches the byte and advances one state.
  - GET_CHK: a strobe latches CHK and moves to EXEC.
  - EXEC: lasts exactly one cycle, then returns to IDLE unconditionally. A strobe arriving in EXEC is dropped.
- EXEC evaluation, in priority order:
  1. Checksum mismatch: err_chk, no side effects.
  2. CMD not in {01,02,03}: err_cmd, no side effects.
  3. SET_SPEED with value < MIN_SPEED: err_cmd, speed unchanged.
  4. Otherwise: update the target output, pulse set_speed (01) or reg_wr_en (02), and pulse frame_ok.
- Latency: strobe of CHK on edge N → state EXEC after edge N → pulse outputs high for the cycle after edge N+1 only. For SET_SPEED, the speed value updates on the same edge as set_speed and is stable while set_speed is high.
- Timeout:
  - Counter clears on every strobe and on entering IDLE.
  - It increments in GET_CMD through GET_CHK.
  - When it reaches TIMEOUT_CYCLES-1 with no strobe: next state IDLE and err_timeout pulses for one cycle.
  - If a strobe arrives in the same cycle the limit is reached, the strobe wins and the counter clears.
- Pulse exclusivity: at most one of frame_ok/err_chk/err_cmd/err_timeout is high in any cycle.
- Reset (reset == 0 at a clk edge):
  - State IDLE; counter 0; rx_valid_q 0.
  - speed = SPEED_DEFAULT; reg_addr, reg_wdata, ctrl_out = 0; all pulses and busy = 0.
  - A reset mid-frame discards the partial frame with no error pulse.
- A SYNC_BYTE value received in the CMD/P0/P1/CHK positions is treated as data; there is no resync.

Test Plan:
- Bytes A5 01 00 20 21 → speed = 0x0020; set_speed and frame_ok each high for exactly 1 cycle, 2 edges after the CHK strobe; busy returns to 0.
- Bytes A5 02 10 5A 48 → reg_wr_en 1-cycle pulse with reg_addr = 0x10, reg_wdata = 0x5A; frame_ok pulses; speed stays 0x1869.
- Bytes A5 02 10 5A 49 → err_chk pulse only; no reg_wr_en; reg_addr/reg_wdata unchanged. A following good frame executes normally.
- Bytes 00 FF A5 03 00 7E 7D, with rx_valid held high for 5 cycles per byte → single strobe per byte; leading 00 FF dropped; ctrl_out = 0x7E; frame_ok pulses.
- Error commands:
  - Bytes A5 01 00 08 09 → err_cmd; speed unchanged.
  - Bytes A5 07 00 00 07 → err_cmd; no other outputs change.
- Timeout and reset:
  - Bytes A5 01, then silence for TIMEOUT_CYCLES → err_timeout pulse once; busy = 0; next full SET_SPEED frame succeeds.
  - Separately, reset = 0 after A5 02 10 → outputs at reset values, no error pulses; the parser accepts a fresh frame.
